// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (core MEM stage vs. CNN loader).
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int PORT_CORE = 0;
  localparam int PORT_EXT  = 1;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_WAIT  = 8;
  localparam int DEF_BURST_MAX = 16;

  // Wait and burst counters cover the 1..255 parameter range.
  localparam int CNT_W = 8;

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating count of consecutive denied external cycles; starve goes high once the
// count reaches MAX_WAIT and stays high until the external master is granted.
module dmem_arb_wait_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic starve
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             starve_r;

  // Next count: a grant clears, a denied request counts up to the ceiling.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (inc && (cnt_r != MAX_WAIT_C)) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter and starve flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      starve_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      starve_r <= (cnt_nxt_s == MAX_WAIT_C);
    end
  end

  assign starve = starve_r;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the core MEM stage and the CNN loader, with
// locked external bursts. Define DMEM_ARB_STARVE_EN to enable external anti-starvation.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_WAIT  = DEF_MAX_WAIT,
  parameter int BURST_MAX = DEF_BURST_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic              ext_req,
  input  logic              ext_lock,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] BURST_MAX_C = CNT_W'(BURST_MAX);

  arb_state_e       state_r;
  arb_state_e       state_nxt_s;
  logic [CNT_W-1:0] burst_cnt_r;
  logic [CNT_W-1:0] burst_cnt_nxt_s;
  logic             forced_r;
  logic             forced_nxt_s;
  logic [1:0]       gnt_s;
  logic             starve_s;

  logic              core_rvalid_r;
  logic              ext_rvalid_r;
  logic [DATA_W-1:0] core_rdata_r;
  logic [DATA_W-1:0] ext_rdata_r;

`ifdef DMEM_ARB_STARVE_EN
  dmem_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk    (clk),
    .rst    (rst),
    .inc    (ext_req & ~gnt_s[PORT_EXT]),
    .clr    (gnt_s[PORT_EXT]),
    .starve (starve_s)
  );
`else
  // Fixed core priority in this build; MAX_WAIT is intentionally left without effect.
  logic [CNT_W-1:0] max_wait_unused_s;
  assign max_wait_unused_s = CNT_W'(MAX_WAIT);
  assign starve_s          = 1'b0;
`endif

  // Arbitration, burst tracking and next state.
  always_comb begin
    gnt_s           = 2'b00;
    state_nxt_s     = state_r;
    burst_cnt_nxt_s = burst_cnt_r;
    forced_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // Right after a forced burst end the core gets first pick, starve or not.
        if (forced_r) begin
          if (core_req) begin
            gnt_s[PORT_CORE] = 1'b1;
          end else if (ext_req) begin
            gnt_s[PORT_EXT] = 1'b1;
          end else begin
            gnt_s = 2'b00;
          end
        end else if (starve_s && ext_req) begin
          gnt_s[PORT_EXT] = 1'b1;
        end else if (core_req) begin
          gnt_s[PORT_CORE] = 1'b1;
        end else if (ext_req) begin
          gnt_s[PORT_EXT] = 1'b1;
        end else begin
          gnt_s = 2'b00;
        end
        if (gnt_s[PORT_EXT] && ext_lock && !forced_r) begin
          // A one-grant burst limit ends the burst on its opening grant.
          if (BURST_MAX_C == CNT_W'(1)) begin
            forced_nxt_s    = 1'b1;
            burst_cnt_nxt_s = {CNT_W{1'b0}};
          end else begin
            state_nxt_s     = LOCK;
            burst_cnt_nxt_s = CNT_W'(1);
          end
        end else begin
          burst_cnt_nxt_s = {CNT_W{1'b0}};
        end
      end
      LOCK: begin
        gnt_s[PORT_EXT] = ext_req;
        if (ext_req && ((burst_cnt_r + CNT_W'(1)) == BURST_MAX_C)) begin
          state_nxt_s     = IDLE;
          burst_cnt_nxt_s = {CNT_W{1'b0}};
          forced_nxt_s    = 1'b1;
        end else if (!ext_lock) begin
          state_nxt_s     = IDLE;
          burst_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (ext_req) begin
          burst_cnt_nxt_s = burst_cnt_r + CNT_W'(1);
        end else begin
          burst_cnt_nxt_s = burst_cnt_r;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        burst_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, burst counter and forced-exit flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      burst_cnt_r <= {CNT_W{1'b0}};
      forced_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      burst_cnt_r <= burst_cnt_nxt_s;
      forced_r    <= forced_nxt_s;
    end
  end

  // Memory-side mux from the granted port; idle bus drives zeros.
  always_comb begin
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (gnt_s[PORT_CORE]) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_read  = ~core_we;
      mem_write = core_we;
    end else if (gnt_s[PORT_EXT]) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_read  = ~ext_we;
      mem_write = ext_we;
    end else begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  // Read return: capture on the grant edge, rvalid for one cycle, data held until next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rvalid_r <= 1'b0;
      ext_rvalid_r  <= 1'b0;
      core_rdata_r  <= {DATA_W{1'b0}};
      ext_rdata_r   <= {DATA_W{1'b0}};
    end else begin
      core_rvalid_r <= gnt_s[PORT_CORE] & ~core_we;
      ext_rvalid_r  <= gnt_s[PORT_EXT] & ~ext_we;
      if (gnt_s[PORT_CORE] && !core_we) begin
        core_rdata_r <= mem_rdata;
      end
      if (gnt_s[PORT_EXT] && !ext_we) begin
        ext_rdata_r <= mem_rdata;
      end
    end
  end

  assign core_gnt    = gnt_s[PORT_CORE];
  assign ext_gnt     = gnt_s[PORT_EXT];
  assign core_stall  = core_req & ~gnt_s[PORT_CORE];
  assign core_rvalid = core_rvalid_r;
  assign core_rdata  = core_rdata_r;
  assign ext_rvalid  = ext_rvalid_r;
  assign ext_rdata   = ext_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_WAIT  = 8;
  localparam int BURST_MAX = 16;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              core_req, core_we, core_gnt, core_stall, core_rvalid;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic              ext_req, ext_lock, ext_we, ext_gnt, ext_rvalid;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata, ext_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_read, mem_write;

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .ext_req(ext_req), .ext_lock(ext_lock), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_lock, m_burst, m_wait, m_forced;
  logic        m_crv, m_erv;
  logic [31:0] m_crd, m_erd;
  logic        exp_gc, exp_ge;
  logic [4:0]  exp_ctl;   // {core_gnt, ext_gnt, core_stall, mem_read, mem_write}
  logic [63:0] exp_bus;   // {mem_addr, mem_wdata}

  function automatic void model_reset();
    m_lock = 0; m_burst = 0; m_wait = 0; m_forced = 0;
    m_crv = 1'b0; m_erv = 1'b0; m_crd = 32'h0; m_erd = 32'h0;
  endfunction

  function automatic void model_eval();
    exp_gc = 1'b0;
    exp_ge = 1'b0;
    if (m_lock != 0) exp_ge = ext_req;
    else if (m_forced != 0) begin
      if (core_req) exp_gc = 1'b1;
      else if (ext_req) exp_ge = 1'b1;
    end
    else if (STARVE_EN && (m_wait == MAX_WAIT) && ext_req) exp_ge = 1'b1;
    else if (core_req) exp_gc = 1'b1;
    else if (ext_req) exp_ge = 1'b1;
    if (exp_gc) begin
      exp_ctl = {1'b1, 1'b0, 1'b0, ~core_we, core_we};
      exp_bus = {core_addr, core_wdata};
    end else if (exp_ge) begin
      exp_ctl = {1'b0, 1'b1, core_req, ~ext_we, ext_we};
      exp_bus = {ext_addr, ext_wdata};
    end else begin
      exp_ctl = {1'b0, 1'b0, core_req, 1'b0, 1'b0};
      exp_bus = 64'h0;
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [5:0] w;
    w = 6'($urandom_range(0, 63));
    return {24'h0, w, 2'b00};
  endfunction

  // One clock: serve the memory, then advance the model by the rules.
  task automatic advance();
    logic        w, gc, ge, cwe, ewe, el, er, wasf;
    logic [31:0] a, d, rd_c, rd_e;
    model_eval();
    w = mem_write; a = mem_addr; d = mem_wdata;
    gc = exp_gc; ge = exp_ge; cwe = core_we; ewe = ext_we; el = ext_lock; er = ext_req;
    rd_c = mem[core_addr[9:2]];
    rd_e = mem[ext_addr[9:2]];
    @(posedge clk);
    if (w) mem[a[9:2]] = d;
    m_crv = gc & ~cwe;
    if (m_crv) m_crd = rd_c;
    m_erv = ge & ~ewe;
    if (m_erv) m_erd = rd_e;
    if (STARVE_EN) begin
      if (ge) m_wait = 0;
      else if (er && (m_wait < MAX_WAIT)) m_wait = m_wait + 1;
    end
    if (m_lock != 0) begin
      if (ge) begin
        m_burst = m_burst + 1;
        if (m_burst == BURST_MAX) begin m_lock = 0; m_forced = 1; m_burst = 0; end
        else if (!el) begin m_lock = 0; m_burst = 0; end
      end else if (!el) begin
        m_lock = 0; m_burst = 0;
      end
    end else begin
      wasf = (m_forced != 0);
      m_forced = 0;
      if (ge && el && !wasf) begin
        if (BURST_MAX == 1) m_forced = 1;
        else begin m_lock = 1; m_burst = 1; end
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    ext_req = 1'b0; ext_lock = 1'b0; ext_we = 1'b0; ext_addr = 32'h0; ext_wdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    mem[4] = 32'hA5C3_0F10;
    clear_inputs();
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({core_rvalid, ext_rvalid, core_rdata, ext_rdata} !== 66'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rv=%b/%b rd=%h/%h required all zero",
               core_rvalid, ext_rvalid, core_rdata, ext_rdata);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({core_gnt, ext_gnt, mem_read, mem_write} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_first_grant: got gnt=%b/%b rd=%b wr=%b required 1/0 1 0",
               core_gnt, ext_gnt, mem_read, mem_write);
    end
    advance();
    core_req = 1'b0;
    #1;
    n_checks++;
    if ({core_rvalid, core_rdata} !== {1'b1, 32'hA5C3_0F10}) begin
      n_fail++;
      $display("FAIL reset_first_read: got rv=%b data=%h required 1 a5c30f10", core_rvalid, core_rdata);
    end
  endtask

  task automatic test_contention();
    int n_ext;
    logic exp_dir;
    do_reset();
    n_ext = 0;
    core_req = 1'b1; core_addr = rand_addr();
    ext_req  = 1'b1; ext_addr  = rand_addr();
    for (int i = 0; i < 27; i++) begin
      #1;
      model_eval();
      exp_dir = STARVE_EN && ((i % 9) == 8);
      n_checks++;
      if ({core_gnt, ext_gnt} !== {~exp_dir, exp_dir}) begin
        n_fail++;
        $display("FAIL contention_pattern cycle %0d: got gnt=%b/%b required %b/%b",
                 i, core_gnt, ext_gnt, ~exp_dir, exp_dir);
      end
      n_checks++;
      if ({core_rvalid, ext_rvalid, core_rdata, ext_rdata} !== {m_crv, m_erv, m_crd, m_erd}) begin
        n_fail++;
        $display("FAIL contention_read cycle %0d: got %b/%b %h/%h required %b/%b %h/%h", i,
                 core_rvalid, ext_rvalid, core_rdata, ext_rdata, m_crv, m_erv, m_crd, m_erd);
      end
      if (ext_gnt === 1'b1) n_ext++;
      advance();
      if (exp_gc) core_addr = rand_addr();
      if (exp_ge) ext_addr = rand_addr();
    end
    n_checks++;
    if (n_ext != (STARVE_EN ? 3 : 0)) begin
      n_fail++;
      $display("FAIL contention_ext_count: got %0d required %0d", n_ext, STARVE_EN ? 3 : 0);
    end
  endtask

  task automatic test_burst();
    int n_late_ext;
    do_reset();
    n_late_ext = 0;
    ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b0; ext_addr = rand_addr();
    core_we = 1'b0; core_addr = rand_addr();
    for (int i = 0; i < 40; i++) begin
      if (i == 1) core_req = 1'b1;
      if (i == 20) ext_lock = 1'b0;
      #1;
      model_eval();
      n_checks++;
      if ({core_gnt, ext_gnt, core_stall} !== exp_ctl[4:2]) begin
        n_fail++;
        $display("FAIL burst_model cycle %0d: got %b%b%b required %b", i,
                 core_gnt, ext_gnt, core_stall, exp_ctl[4:2]);
      end
      if (i < 16) begin
        n_checks++;
        if ({core_gnt, ext_gnt, core_stall} !== {1'b0, 1'b1, (i > 0)}) begin
          n_fail++;
          $display("FAIL burst_locked cycle %0d: got %b%b%b required 01%b", i,
                   core_gnt, ext_gnt, core_stall, (i > 0));
        end
      end else if (i == 16) begin
        n_checks++;
        if ({core_gnt, ext_gnt} !== 2'b10) begin
          n_fail++;
          $display("FAIL burst_forced_exit: got gnt=%b/%b required 1/0", core_gnt, ext_gnt);
        end
      end else if (ext_gnt === 1'b1) begin
        n_late_ext++;
      end
      advance();
      if (exp_gc) core_addr = rand_addr();
      if (exp_ge) ext_addr = rand_addr();
    end
    n_checks++;
    if ((n_late_ext > 0) !== STARVE_EN) begin
      n_fail++;
      $display("FAIL burst_regrant: got %0d later ext grants, starve build=%0d", n_late_ext, STARVE_EN);
    end
    clear_inputs();
  endtask

  task automatic test_write_read();
    do_reset();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({ext_gnt, mem_write, mem_read, mem_addr, mem_wdata} !== {3'b110, 32'h40, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL ext_write: got gnt=%b wr=%b rd=%b a=%h d=%h required 1 1 0 00000040 deadbeef",
               ext_gnt, mem_write, mem_read, mem_addr, mem_wdata);
    end
    advance();
    ext_req = 1'b0; ext_we = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    #1;
    n_checks++;
    if ({core_gnt, mem_write, mem_read, ext_rvalid} !== 4'b1010) begin
      n_fail++;
      $display("FAIL core_read_issue: got gnt=%b wr=%b rd=%b erv=%b required 1 0 1 0",
               core_gnt, mem_write, mem_read, ext_rvalid);
    end
    advance();
    core_req = 1'b0;
    #1;
    n_checks++;
    if ({core_rvalid, core_rdata, ext_rvalid} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
      n_fail++;
      $display("FAIL core_read_data: got rv=%b d=%h erv=%b required 1 deadbeef 0",
               core_rvalid, core_rdata, ext_rvalid);
    end
    advance();
    #1;
    n_checks++;
    if (core_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rvalid_pulse: got %b required 0", core_rvalid);
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b0; ext_addr = rand_addr();
    core_we = 1'b0; core_addr = rand_addr();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) core_req = 1'b1;
      #1;
      n_checks++;
      if (ext_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL midlock_grant cycle %0d: got %b required 1", i, ext_gnt);
      end
      advance();
    end
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ext_rvalid, core_rvalid, ext_gnt, core_gnt} !== 4'b0001) begin
      n_fail++;
      $display("FAIL midlock_reset: got erv=%b crv=%b gnt=%b/%b required 0 0 0/1",
               ext_rvalid, core_rvalid, ext_gnt, core_gnt);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    model_eval();
    n_checks++;
    if ({core_gnt, ext_gnt} !== 2'b10 || exp_gc !== 1'b1) begin
      n_fail++;
      $display("FAIL midlock_release: got gnt=%b/%b required 1/0", core_gnt, ext_gnt);
    end
    advance();
    #1;
    n_checks++;
    if ({core_rvalid, core_rdata} !== {m_crv, m_crd}) begin
      n_fail++;
      $display("FAIL midlock_read: got %b %h required %b %h", core_rvalid, core_rdata, m_crv, m_crd);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic last_gc, last_ge;
    do_reset();
    last_gc = 1'b0; last_ge = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!core_req || last_gc) begin
        core_req = ($urandom_range(0, 3) != 0);
        core_we = 1'($urandom_range(0, 1)); core_addr = rand_addr(); core_wdata = $urandom();
      end
      if (!ext_req || last_ge) begin
        ext_req = ($urandom_range(0, 1) != 0);
        ext_we = 1'($urandom_range(0, 1)); ext_addr = rand_addr(); ext_wdata = $urandom();
      end
      ext_lock = ($urandom_range(0, 3) != 0);
      #1;
      model_eval();
      n_checks++;
      if ({core_gnt, ext_gnt, core_stall, mem_read, mem_write} !== exp_ctl) begin
        n_fail++;
        $display("FAIL random_ctl cycle %0d: got %b%b%b%b%b required %b", i,
                 core_gnt, ext_gnt, core_stall, mem_read, mem_write, exp_ctl);
      end
      n_checks++;
      if ({mem_addr, mem_wdata} !== exp_bus) begin
        n_fail++;
        $display("FAIL random_bus cycle %0d: got %h %h required %h", i, mem_addr, mem_wdata, exp_bus);
      end
      n_checks++;
      if ({core_rvalid, ext_rvalid} !== {m_crv, m_erv}) begin
        n_fail++;
        $display("FAIL random_rvalid cycle %0d: got %b%b required %b%b", i,
                 core_rvalid, ext_rvalid, m_crv, m_erv);
      end
      n_checks++;
      if ({core_rdata, ext_rdata} !== {m_crd, m_erd}) begin
        n_fail++;
        $display("FAIL random_rdata cycle %0d: got %h/%h required %h/%h", i,
                 core_rdata, ext_rdata, m_crd, m_erd);
      end
      last_gc = exp_gc;
      last_ge = exp_ge;
      advance();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    for (int k = 0; k < 256; k++) mem[k] = $urandom();
    test_reset();
    test_contention();
    test_burst();
    test_write_read();
    test_reset_mid_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between the pipelined core's MEM stage and one external master, the CNN weight/activation loader. It sits between the EX/MEM pipeline register outputs and the data memory. It issues at most one access per cycle and returns registered read data to the winning requester one cycle later. It also drives the core stall request consumed by the pipeline hazard logic.

## Interface
Parameters:
- ADDR_W, 32, address width (byte address, passed through unchanged)
- DATA_W, 32, data width
- MAX_WAIT, 8, consecutive denied cycles before the external master gets priority (1..255)
- BURST_MAX, 16, maximum consecutive external grants under lock (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- core_req  in  1  core access request (MEM-stage memread | memwrite)
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address (ALU result)
- core_wdata  in  DATA_W  core store data
- core_gnt  out  1  core access issued this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rdata  out  DATA_W  registered read data
- core_rvalid  out  1  core_rdata valid (one-cycle pulse)
- ext_req  in  1  external access request
- ext_lock  in  1  request exclusive burst
- ext_we, ext_addr, ext_wdata  in  1/ADDR_W/DATA_W  as for the core
- ext_gnt  out  1  external access issued this cycle
- ext_rdata  out  DATA_W  registered read data
- ext_rvalid  out  1  ext_rdata valid (one-cycle pulse)
- mem_addr, mem_wdata  out  ADDR_W/DATA_W  to data memory
- mem_read, mem_write  out  1  to data memory
- mem_rdata  in  DATA_W  combinational read data from data memory

## Operation
- FSM states: IDLE, LOCK.
- IDLE arbitration, in priority order:
  1. If the starve flag is set and ext_req: grant ext.
  2. Else if core_req: grant core.
  3. Else if ext_req: grant ext.
- An ext grant in IDLE with ext_lock=1 moves to LOCK. The burst counter loads 1.
- LOCK: ext is the only requester granted, whenever ext_req=1. Each ext grant increments the burst counter.
- LOCK exits to IDLE when ext_lock=0 is sampled, or on the edge of the grant that brings the counter to BURST_MAX.
- After a forced exit (counter reached BURST_MAX), the next IDLE cycle ignores the starve flag and ext_lock. If core_req is set, the core wins that cycle.
- Wait counter: increments, saturating at MAX_WAIT, every cycle with ext_req & ~ext_gnt. It clears on any ext grant. The starve flag is asserted when count == MAX_WAIT.
- Memory outputs:
  - mem_addr, mem_wdata and mem_write come combinationally from the granted port.
  - mem_read = gnt & ~we.
  - With no grant, all memory outputs are 0.
- Reads: on the grant edge, mem_rdata is captured into the winner's rdata register and its rvalid is set for the following cycle only.
- Writes: no rvalid.
- The rdata registers hold their value until the next read for that port.
- Requests are level-held. A requester must keep req and its address/data stable until it sees gnt.

## Timing
- Grant is combinational in the same cycle as the request.
- Read latency: 1 cycle (rvalid in cycle N+1 for a grant in cycle N). Back-to-back reads give back-to-back rvalids.
- Throughput: one access per cycle.
- Reset (rst=0, asynchronous), values held while asserted:
  - state = IDLE, counters = 0, starve flag = 0
  - core_rvalid = ext_rvalid = 0, core_rdata = ext_rdata = 0
- Grants follow from the reset state:
  - core_gnt is 1 if core_req is set.
  - ext_gnt is set only per the IDLE rules.
  - mem_read and mem_write are 0 unless a grant is active.
- Reset mid-burst drops LOCK immediately. A pending rvalid is lost.
- If core and ext request in the same cycle with no starve flag, the core wins and the ext wait counter increments.
- ext_lock=1 while already in LOCK with ext_req=0: stay in LOCK, no grant, counter unchanged.
- MAX_WAIT=1: ext wins every other contended cycle.

## Configuration
- DMEM_ARB_STARVE_EN defined: the wait counter and starve flag operate as above.
- DMEM_ARB_STARVE_EN undefined: no wait counter. IDLE uses fixed core priority, and ext is served only when core_req=0. MAX_WAIT is unused.
- LOCK behaviour is identical in both builds.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, LOCK)
  - port index constants PORT_CORE=0 and PORT_EXT=1
  - default width constants
- One sub-module: dmem_arb_wait_ctr. It is the saturating wait counter plus starve flag, with ports clk, rst, inc, clr, starve and parameter MAX_WAIT. It is instantiated only under DMEM_ARB_STARVE_EN.

## Test plan
- Reset with core_req=1, core_we=0, addr 0x10 held: after rst rises, core_gnt=1 and mem_read=1 that cycle; next cycle core_rvalid=1 and core_rdata equals the memory word at 0x10.
- Core and ext both requesting continuously, MAX_WAIT=8, starve enabled: core is granted 8 cycles, ext on the 9th, then the pattern repeats. With the macro undefined, ext is never granted.
- Ext burst with ext_lock=1 held for 20 cycles, BURST_MAX=16, core_req=1: 16 ext grants with core_stall=1; the 17th cycle grants core; ext is re-granted afterwards.
- Ext write of 0xDEADBEEF to 0x40, then core read of 0x40: mem_write=1 only in the ext grant cycle; core_rvalid shows 0xDEADBEEF; ext_rvalid stays 0.
- rst pulsed low mid-LOCK, 5 grants into a burst: state returns to IDLE and rvalids clear immediately; after release a pending core_req is granted in the first cycle.
